conv_accumulator: RTL and testbench

//  Downstream of the signed multiplier stage in the conv datapath. Sums NUM_TAPS signed

---
 rtl/cnn_pkg.sv | 37 +++
 rtl/conv_requant.sv | 52 +++++
 rtl/conv_accumulator.sv | 158 +++++++++++++++
 tb/tb_conv_accumulator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared definitions for the conv datapath stages: default
//                operand/tap constants, accumulator state encodings and a
//                constant-foldable ceil(log2) helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cnn_pkg;

  // Defaults shared with the multiplier and line-buffer stages.
  localparam int CNN_BIT_SIZE = 8;
  localparam int CNN_NUM_TAPS = 9;

  // Accumulator state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_HOLD  = ST_HOLD
  } acc_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int cnn_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/conv_requant.sv
`default_nettype none
// ============================================================================
//  Module      : conv_requant
//  Description : Combinational requantizer. Arithmetic (floor) right shift of
//                the accumulator by OUT_SHIFT, optional ReLU, then signed
//                saturation to OUT_WIDTH bits.
//  Config      : CONV_ACC_RELU_EN - negative shifted values forced to zero
//                before saturation (sat then only flags positive overflow).
//  Ports       : acc_in   [ACC_WIDTH-1:0]  signed accumulator value
//                out_data [OUT_WIDTH-1:0]  signed requantized value
//                sat                       value was clamped
//  Revision    : 1.0  initial release
// ============================================================================
module conv_requant #(
  parameter int ACC_WIDTH = 21,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 sat
);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic        [ACC_WIDTH-1:0] w_t;
  logic                        w_fits;

  assign w_shifted = $signed(acc_in) >>> OUT_SHIFT;

`ifdef CONV_ACC_RELU_EN
  assign w_t = w_shifted[ACC_WIDTH-1] ? '0 : w_shifted;
`else
  assign w_t = w_shifted;
`endif

  // The value fits when every bit above the output sign bit is a copy of it.
  assign w_fits = (&w_t[ACC_WIDTH-1:OUT_WIDTH-1]) | ~(|w_t[ACC_WIDTH-1:OUT_WIDTH-1]);

  always_comb begin
    out_data = w_t[OUT_WIDTH-1:0];
    sat      = 1'b0;
    if (!w_fits) begin
      sat      = 1'b1;
      out_data = w_t[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
    end
  end

endmodule : conv_requant
`default_nettype wire

// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accumulator
//  Description : Sums NUM_TAPS signed products of one kernel window onto a
//                preloaded bias, requantizes the total (shift + saturate) and
//                presents one result per window on a valid/ready handshake.
//  Config      : CONV_ACC_RELU_EN - output clamped at zero from below.
//  Ports       : clk, reset (async, active-high)
//                start/start_ready/bias    window start with bias preload
//                prod_in/prod_valid/in_ready  product input
//                out_data/out_valid/out_ready/out_sat  result handshake
//                abort                     pulse when start restarts a
//                                          partially accumulated window
//  Revision    : 1.0  initial release
// ============================================================================
module conv_accumulator
  import cnn_pkg::*;
#(
  parameter int BIT_SIZE  = CNN_BIT_SIZE,
  parameter int NUM_TAPS  = CNN_NUM_TAPS,
  parameter int ACC_WIDTH = 2*BIT_SIZE + cnn_clog2(NUM_TAPS) + 1,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  start_ready,
  input  logic [2*BIT_SIZE-1:0] bias,
  input  logic [2*BIT_SIZE-1:0] prod_in,
  input  logic                  prod_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sat,
  output logic                  abort
);

  localparam int PROD_W = 2*BIT_SIZE;
  localparam int EXT_W  = ACC_WIDTH - PROD_W;
  localparam int CNT_W  = (cnn_clog2(NUM_TAPS + 1) < 1) ? 1 : cnn_clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(NUM_TAPS - 1);

  acc_state_e             state_q,     state_d;
  logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]       tap_cnt_q,   tap_cnt_d;
  logic [OUT_WIDTH-1:0]   out_data_q,  out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sat_q,   out_sat_d;
  logic                   abort_q,     abort_d;

  logic [ACC_WIDTH-1:0]   w_bias_ext;
  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-1:0]   w_acc_sum;
  logic [OUT_WIDTH-1:0]   w_rq_data;
  logic                   w_rq_sat;

  assign w_bias_ext = {{EXT_W{bias[PROD_W-1]}}, bias};
  assign w_prod_ext = {{EXT_W{prod_in[PROD_W-1]}}, prod_in};
  assign w_acc_sum  = acc_q + w_prod_ext;

  // Requantize the running sum including the current product so the final
  // result can be registered on the same edge that accepts the last tap.
  conv_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .acc_in   (w_acc_sum),
    .out_data (w_rq_data),
    .sat      (w_rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    abort_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d     = w_bias_ext;
          tap_cnt_d = '0;
          state_d   = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (start) begin
          // Restart wins over a coincident product; the product is dropped.
          acc_d     = w_bias_ext;
          tap_cnt_d = '0;
          abort_d   = (tap_cnt_q != '0);
        end else if (prod_valid) begin
          acc_d = w_acc_sum;
          if (tap_cnt_q == TAP_LAST) begin
            tap_cnt_d   = '0;
            out_data_d  = w_rq_data;
            out_sat_d   = w_rq_sat;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            acc_d     = w_bias_ext;
            tap_cnt_d = '0;
            state_d   = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      abort_q     <= abort_d;
    end
  end

  assign in_ready    = (state_q == S_ACCUM);
  assign start_ready = (state_q != S_HOLD) || out_ready;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sat     = out_sat_q;
  assign abort       = abort_q;

endmodule : conv_accumulator
`default_nettype wire

// File: tb/tb_conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_accumulator
//  Description : Self-checking bench for conv_accumulator with a behavioural
//                window model (plain integer sum, floor shift, clamp).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start_ready;
  logic [15:0] bias;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic        abort;

  int errors = 0;
  int checks = 0;

  conv_accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_ready (start_ready),
    .bias        (bias),
    .prod_in     (prod_in),
    .prod_valid  (prod_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sat     (out_sat),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: window total -> floor(total / 16) -> optional ReLU -> clamp.
  function automatic void ref_result(input longint total, output logic [7:0] q, output logic sat);
    longint t;
    t = total >>> 4;
`ifdef CONV_ACC_RELU_EN
    if (t < 0) t = 0;
`endif
    sat = 1'b0;
    if (t > 127) begin
      t = 127; sat = 1'b1;
    end else if (t < -128) begin
      t = -128; sat = 1'b1;
    end
    q = t[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
    bias = '0; prod_in = '0;
  endtask

  // Runs one window and its output handshake, checking against the model.
  task automatic run_window(input string name, input int b, input int prods[$],
                            input int max_gap, input int stall, input bit noise,
                            input bit restart, input int next_b, input bit no_start);
    longint     total;
    logic [7:0] exp_q;
    logic       exp_sat;
    int         gap;
    int         r;
    total     = b;
    out_ready = (stall == 0);
    if (!no_start) begin
      checks++;
      if (start_ready !== 1'b1) begin
        errors++; $display("FAIL %s start_ready_idle: got %b want 1", name, start_ready);
      end
      start = 1'b1; bias = b[15:0];
      step();
      start = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_accum: got %b want 1", name, in_ready);
    end
    for (int i = 0; i < prods.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        prod_valid = 1'b0; prod_in = 16'($urandom);
        step();
      end
      r = prods[i];
      prod_valid = 1'b1; prod_in = r[15:0];
      total += r;
      step();
      prod_valid = 1'b0;
      checks++;
      if (abort !== 1'b0) begin
        errors++; $display("FAIL %s abort_spurious tap%0d: got %b want 0", name, i, abort);
      end
      if (i < prods.size() - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL %s early_valid tap%0d: got %b want 0", name, i, out_valid);
        end
      end
    end
    ref_result(total, exp_q, exp_sat);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q || out_sat !== exp_sat) begin
      errors++;
      $display("FAIL %s result: got valid=%b data=%0d sat=%b want valid=1 data=%0d sat=%b (total=%0d)",
               name, out_valid, $signed(out_data), out_sat, $signed(exp_q), exp_sat, total);
    end
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        start = 1'b1; bias = next_b[15:0];
        prod_valid = 1'b1; prod_in = 16'($urandom);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q || out_sat !== exp_sat ||
          in_ready !== 1'b0 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_stable cyc%0d: got valid=%b data=%0d sat=%b in_ready=%b start_ready=%b want 1/%0d/%b/0/0",
                 name, s, out_valid, $signed(out_data), out_sat, in_ready, start_ready, $signed(exp_q), exp_sat);
      end
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    start      = restart;
    bias       = next_b[15:0];
    step();
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== restart) begin
      errors++;
      $display("FAIL %s handshake: got valid=%b in_ready=%b want valid=0 in_ready=%b",
               name, out_valid, in_ready, restart);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (out_data !== 8'd0 || out_valid !== 1'b0 || out_sat !== 1'b0 || abort !== 1'b0 ||
        in_ready !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got data=%0d valid=%b sat=%b abort=%b in_ready=%b start_ready=%b want 0/0/0/0/0/1",
               out_data, out_valid, out_sat, abort, in_ready, start_ready);
    end
    step(); step();
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    int p[$];
    p = {}; for (int i = 0; i < 9; i++) p.push_back(16);
    run_window("basic16", 0, p, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    p = {}; for (int i = 0; i < 9; i++) p.push_back(16129);
    run_window("saturate_pos", 0, p, 0, 1, 1'b0, 1'b0, 0, 1'b0);
    p = {}; for (int i = 0; i < 9; i++) p.push_back(-100);
    run_window("negative", -4, p, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    p = {}; for (int i = 0; i < 9; i++) p.push_back(-30000);
    run_window("saturate_neg", -32768, p, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_abort();
    int p[$];
    start = 1'b1; bias = 16'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1; prod_in = 16'd50;
      step();
    end
    start = 1'b1; prod_valid = 1'b1; prod_in = 16'd50; bias = 16'd0;
    step();
    start = 1'b0; prod_valid = 1'b0;
    checks++;
    if (abort !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_pulse: got abort=%b in_ready=%b want 1/1", abort, in_ready);
    end
    p = {}; for (int i = 0; i < 9; i++) p.push_back(16);
    run_window("after_abort", 0, p, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    // Start on a fresh window with no taps yet must not abort.
    start = 1'b1; bias = 16'd0;
    step();
    step();
    checks++;
    if (abort !== 1'b0) begin
      errors++; $display("FAIL abort_empty_restart: got %b want 0", abort);
    end
    start = 1'b0;
    run_window("empty_restart", 0, p, 0, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_hold_stall();
    int p[$];
    p = {}; for (int i = 0; i < 9; i++) p.push_back(16);
    run_window("hold_stall", 100, p, 0, 5, 1'b1, 1'b1, 0, 1'b0);
    run_window("post_stall", 0, p, 0, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_async_reset();
    int p[$];
    start = 1'b1; bias = 16'd5000;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1; prod_in = 16'd1000;
      step();
    end
    prod_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_data !== 8'd0 || out_valid !== 1'b0 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_accum: got data=%0d valid=%b sat=%b in_ready=%b want 0/0/0/0",
                         out_data, out_valid, out_sat, in_ready);
    end
    @(posedge clk); #2 reset = 1'b0;
    step();
    start = 1'b1; bias = 16'd1000;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      prod_valid = 1'b1; prod_in = 16'd500;
      step();
    end
    prod_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
      errors++; $display("FAIL pre_reset_hold: got valid=%b sat=%b want 1/1", out_valid, out_sat);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (out_data !== 8'd0 || out_valid !== 1'b0 || out_sat !== 1'b0 || start_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_hold: got data=%0d valid=%b sat=%b start_ready=%b want 0/0/0/1",
                         out_data, out_valid, out_sat, start_ready);
    end
    @(posedge clk); #2 reset = 1'b0;
    step();
    p = {}; for (int i = 0; i < 9; i++) p.push_back(16);
    run_window("after_reset", 0, p, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    int p[$];
    int b;
    bit big;
    for (int w = 0; w < 12; w++) begin
      p = {};
      big = 1'($urandom_range(0, 1));
      for (int i = 0; i < 9; i++) begin
        if (big) p.push_back(int'($urandom_range(0, 65535)) - 32768);
        else     p.push_back(int'($urandom_range(0, 600)) - 300);
      end
      b = big ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
      run_window($sformatf("random%0d", w), b, p, 2, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_hold_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_conv_accumulator
`default_nettype wire
